// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/multiply ops plus an iterative restoring divider,
// with valid/ready handshakes on both request and result sides.
module alu_mc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero
);

  typedef enum logic [1:0] {StIdle, StBusy, StHold} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic             rem_sel_q, neg_q_q, neg_r_q, dz_q;

  logic accept, is_div, last;
  assign accept = in_valid & in_ready;
  assign is_div = (alu_op >= 5'd15) && (alu_op <= 5'd18);
  assign last   = (cnt_q == SHW'(WIDTH - 1));

  // Single-cycle datapath; signed high product is derived from the unsigned one.
  logic [2*WIDTH-1:0] prod_u;
  logic [WIDTH-1:0]   mulh_s, alu_res;
  logic [SHW-1:0]     sh;

  always_comb begin
    sh      = r2[SHW-1:0];
    prod_u  = {{WIDTH{1'b0}}, r1} * {{WIDTH{1'b0}}, r2};
    mulh_s  = prod_u[2*WIDTH-1:WIDTH] - (r1[WIDTH-1] ? r2 : '0) - (r2[WIDTH-1] ? r1 : '0);
    alu_res = '0;
    case (alu_op)
      5'd0:    alu_res = r1 + r2;
      5'd1:    alu_res = r1 - r2;
      5'd2:    alu_res = r1 & r2;
      5'd3:    alu_res = r1 | r2;
      5'd4:    alu_res = r1 ^ r2;
      5'd5:    alu_res = ~(r1 ^ r2);
      5'd6:    alu_res = ~r1;
      5'd7:    alu_res = r1 << sh;
      5'd8:    alu_res = r1 >> sh;
      5'd9:    alu_res = $signed(r1) >>> sh;
      5'd10:   alu_res = prod_u[WIDTH-1:0];
      5'd11:   alu_res = mulh_s;
      5'd12:   alu_res = prod_u[2*WIDTH-1:WIDTH];
      5'd13:   alu_res = {{(WIDTH-1){1'b0}}, $signed(r1) < $signed(r2)};
      5'd14:   alu_res = {{(WIDTH-1){1'b0}}, r1 < r2};
      default: alu_res = '0;
    endcase
  end

  // Divider operand preparation and one restoring iteration.
  logic             div_sgn, div_rem;
  logic [WIDTH-1:0] mag1, mag2, rem_nx, quo_nx, div_res;
  logic [WIDTH:0]   rem_sh, diff;

  always_comb begin
    div_sgn = (alu_op == 5'd15) || (alu_op == 5'd17);
    div_rem = (alu_op == 5'd17) || (alu_op == 5'd18);
    mag1    = (div_sgn && r1[WIDTH-1]) ? -r1 : r1;
    mag2    = (div_sgn && r2[WIDTH-1]) ? -r2 : r2;
    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, dvs_q};
    rem_nx  = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_nx  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    // Divide-by-zero quotient is forced; the remainder path already yields r1 naturally.
    if (rem_sel_q) begin
      div_res = neg_r_q ? -rem_nx : rem_nx;
    end else if (dz_q) begin
      div_res = '1;
    end else begin
      div_res = neg_q_q ? -quo_nx : quo_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = is_div ? StBusy : StHold;
      StBusy: if (last) state_d = StHold;
      StHold: begin
        if (accept)         state_d = is_div ? StBusy : StHold;
        else if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle:  in_ready = 1'b1;
      StBusy:  in_ready = 1'b0;
      StHold: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // res is kept at zero whenever no result is pending.
  always_comb begin
    res_d = res_q;
    if (accept)                          res_d = is_div ? '0 : alu_res;
    else if (state_q == StBusy && last)  res_d = div_res;
    else if (state_q == StHold && out_ready) res_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q     <= '0;
      zero_q    <= 1'b1;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      rem_sel_q <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      res_q  <= res_d;
      zero_q <= (res_d == '0);
      if (accept && is_div) begin
        cnt_q     <= '0;
        quo_q     <= mag1;
        rem_q     <= '0;
        dvs_q     <= mag2;
        rem_sel_q <= div_rem;
        neg_q_q   <= div_sgn && (r1[WIDTH-1] ^ r2[WIDTH-1]);
        neg_r_q   <= div_sgn && r1[WIDTH-1];
        dz_q      <= (r2 == '0);
      end else if (state_q == StBusy) begin
        cnt_q <= cnt_q + 1'b1;
        quo_q <= quo_nx;
        rem_q <= rem_nx;
      end
    end
  end

  assign res  = res_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed, table-driven bench for alu_mc (WIDTH=32) plus hand-written handshake/reset sequences.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  alu_op;
  logic [31:0] r1, r2;
  logic        out_valid, out_ready;
  logic [31:0] res;
  logic        zero;

  int n_checks = 0;
  int n_fail   = 0;

  alu_mc #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .r1        (r1),
    .r2        (r2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam int NVEC = 30;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issues one op with out_ready=1; during a divide a spurious request is held to show it is ignored.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] got, output logic got_zero, output int lat,
                       output logic busy_bad);
    logic div;
    div = (op >= 5'd15) && (op <= 5'd18);
    @(negedge clk);
    in_valid = 1'b1; alu_op = op; r1 = a; r2 = b; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = div; alu_op = 5'd0; r1 = ~a; r2 = ~b;
    lat = 0; busy_bad = 1'b0; got = '0; got_zero = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (in_ready) busy_bad = 1'b1;
    end
    in_valid = 1'b0;
    got = res; got_zero = zero;
    @(posedge clk);
  endtask

  logic [31:0] got;
  logic        gz, bb;
  int          lat, wait_n;
  bit          saw;

  initial begin
    vecs[0]  = '{5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000};
    vecs[1]  = '{5'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE};
    vecs[2]  = '{5'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    vecs[3]  = '{5'd3,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0};
    vecs[4]  = '{5'd4,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555};
    vecs[5]  = '{5'd5,  32'h00000000, 32'h00000000, 32'hFFFFFFFF};
    vecs[6]  = '{5'd6,  32'h12345678, 32'h00000000, 32'hEDCBA987};
    vecs[7]  = '{5'd7,  32'h00000001, 32'h00000021, 32'h00000002};
    vecs[8]  = '{5'd9,  32'h80000000, 32'h00000024, 32'hF8000000};
    vecs[9]  = '{5'd8,  32'h80000000, 32'h00000024, 32'h08000000};
    vecs[10] = '{5'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[11] = '{5'd11, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[12] = '{5'd11, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
    vecs[13] = '{5'd12, 32'hFFFFFFFF, 32'h00000002, 32'h00000001};
    vecs[14] = '{5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[15] = '{5'd13, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    vecs[16] = '{5'd14, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vecs[17] = '{5'd20, 32'h12345678, 32'h11111111, 32'h00000000};
    vecs[18] = '{5'd15, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD};
    vecs[19] = '{5'd17, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF};
    vecs[20] = '{5'd15, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD};
    vecs[21] = '{5'd17, 32'h00000007, 32'hFFFFFFFE, 32'h00000001};
    vecs[22] = '{5'd16, 32'h00000005, 32'h00000000, 32'hFFFFFFFF};
    vecs[23] = '{5'd18, 32'h00000005, 32'h00000000, 32'h00000005};
    vecs[24] = '{5'd15, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[25] = '{5'd17, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    vecs[26] = '{5'd16, 32'h00000064, 32'h00000007, 32'h0000000E};
    vecs[27] = '{5'd18, 32'h00000064, 32'h00000007, 32'h00000002};
    vecs[28] = '{5'd15, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF};
    vecs[29] = '{5'd17, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB};

    rst = 1'b1; in_valid = 1'b0; alu_op = '0; r1 = '0; r2 = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset res", res, 32'd0);
    check("reset zero", {31'd0, zero}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready after reset", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < NVEC; i++) begin
      logic d;
      d = (vecs[i].op >= 5'd15) && (vecs[i].op <= 5'd18);
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, got, gz, lat, bb);
      check($sformatf("vec%0d op%0d res", i, vecs[i].op), got, vecs[i].exp);
      check($sformatf("vec%0d zero", i), {31'd0, gz}, {31'd0, vecs[i].exp == 32'd0});
      check($sformatf("vec%0d latency", i), lat, d ? 32'd33 : 32'd1);
      if (d) check($sformatf("vec%0d in_ready low in BUSY", i), {31'd0, bb}, 32'd0);
    end

    // Back-to-back SUB 3-3 then AND F0&0F with the first result stalled for 3 cycles.
    @(negedge clk);
    in_valid = 1'b1; alu_op = 5'd1; r1 = 32'd3; r2 = 32'd3; out_ready = 1'b0;
    @(posedge clk); #1;
    alu_op = 5'd2; r1 = 32'hF0; r2 = 32'h0F;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d out_valid", c), {31'd0, out_valid}, 32'd1);
      check($sformatf("stall%0d res", c), res, 32'd0);
      check($sformatf("stall%0d zero", c), {31'd0, zero}, 32'd1);
      check($sformatf("stall%0d in_ready", c), {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    check("stall4 out_valid", {31'd0, out_valid}, 32'd1);
    check("stall4 zero", {31'd0, zero}, 32'd1);
    #1 check("release in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("second out_valid", {31'd0, out_valid}, 32'd1);
    check("second res", res, 32'd0);
    check("second zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    check("after pair out_valid", {31'd0, out_valid}, 32'd0);

    // Throughput 1/cycle, then HOLD->BUSY on a same-cycle divide.
    @(negedge clk);
    in_valid = 1'b1; alu_op = 5'd0; r1 = 32'd1; r2 = 32'd2; out_ready = 1'b1;
    @(negedge clk);
    check("b2b first res", res, 32'd3);
    alu_op = 5'd1; r1 = 32'd10; r2 = 32'd4;
    @(negedge clk);
    check("b2b second res", res, 32'd6);
    check("b2b second valid", {31'd0, out_valid}, 32'd1);
    alu_op = 5'd16; r1 = 32'd100; r2 = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      wait_n++;
      if (out_valid) break;
    end
    check("hold->busy latency", wait_n, 32'd33);
    check("hold->busy DIVU res", res, 32'd14);
    @(negedge clk);

    // Reset during a pending result clears it.
    in_valid = 1'b1; alu_op = 5'd0; r1 = 32'd5; r2 = 32'd6; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("pending valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst hold out_valid", {31'd0, out_valid}, 32'd0);
    check("rst hold res", res, 32'd0);
    check("rst hold zero", {31'd0, zero}, 32'd1);
    out_ready = 1'b1;

    // Reset in cycle 10 of a divide aborts it.
    @(negedge clk);
    in_valid = 1'b1; alu_op = 5'd15; r1 = 32'hFFFFFFF9; r2 = 32'd2;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort in_ready", {31'd0, in_ready}, 32'd1);
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    check("abort no out_valid", {31'd0, saw}, 32'd0);
    do_op(5'd12, 32'hFFFFFFFF, 32'd2, got, gz, lat, bb);
    check("post-abort MULHU res", got, 32'd1);
    check("post-abort MULHU latency", lat, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
